// File: rtl/cpu_axi_arbiter_pkg.sv
// Shared types for the CPU-side AXI arbiter: FSM states, owner encoding,
// SRAM-like access sizes and the latched request record.
package cpu_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        owner_t      owner;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

endpackage

// File: rtl/cpu_axi_arbiter_wstrb_gen.sv
// Byte-lane strobe decode from access size and the low address bits.
module axi_wstrb_gen
    import cpu_axi_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_addr,
    output logic [3:0] o_wstrb
);

    always_comb begin
        o_wstrb = 4'b1111;
        case (i_size)
            SZ_BYTE: o_wstrb = 4'b0001 << i_addr;
            SZ_HALF: o_wstrb = i_addr[1] ? 4'b1100 : 4'b0011;
            default: o_wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/cpu_axi_arbiter.sv
// Shares one AXI master between the instruction and data SRAM-like ports.
// One transaction in flight; data wins over instruction on a tie.
module cpu_axi_arbiter
    import cpu_axi_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] cpu_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    state_t      r_state;
    state_t      w_state_nxt;
    req_t        r_req;
    req_t        w_acc_req;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_inst_ok;
    logic        r_data_ok;
    logic [31:0] r_rdata;

    logic        w_idle;
    logic        w_data_acc;
    logic        w_inst_acc;
    logic        w_acc;
    logic [1:0]  w_acc_size;
    logic [31:0] w_acc_addr;
    logic [3:0]  w_acc_wstrb;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_aw_done_nxt;
    logic        w_w_done_nxt;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_data_acc = w_idle && data_req;
    assign w_inst_acc = w_idle && inst_req && !data_req;
    assign w_acc      = w_data_acc || w_inst_acc;

    // Gated by reset so the handshakes stay low while reset is held.
    assign data_addr_ok = aresetn && w_data_acc;
    assign inst_addr_ok = aresetn && w_inst_acc;

    assign w_acc_size = w_data_acc ? data_size : SZ_WORD;
    assign w_acc_addr = w_data_acc ? data_addr : inst_addr;

    axi_wstrb_gen u_wstrb_gen (
        .i_size  (w_acc_size),
        .i_addr  (w_acc_addr[1:0]),
        .o_wstrb (w_acc_wstrb)
    );

    always_comb begin
        w_acc_req       = '0;
        w_acc_req.owner = w_data_acc ? OWN_DATA : OWN_INST;
        w_acc_req.size  = w_acc_size;
        w_acc_req.addr  = w_acc_addr;
        w_acc_req.wdata = w_data_acc ? data_wdata : 32'd0;
        w_acc_req.wstrb = w_acc_wstrb;
    end

    assign w_aw_fire     = (r_state == ST_WR_ADDR) && !r_aw_done && awready;
    assign w_w_fire      = (r_state == ST_WR_ADDR) && !r_w_done && wready;
    assign w_aw_done_nxt = r_aw_done || w_aw_fire;
    assign w_w_done_nxt  = r_w_done || w_w_fire;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awvalid     = 1'b0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) w_state_nxt = (w_data_acc && data_wr) ? ST_WR_ADDR : ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) w_state_nxt = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rready = 1'b1;
                if (rvalid) w_state_nxt = ST_IDLE;
            end
            ST_WR_ADDR: begin
                // AW and W retire independently; leave once both have.
                awvalid = !r_aw_done;
                wvalid  = !r_w_done;
                if (w_aw_done_nxt && w_w_done_nxt) w_state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (bvalid) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_req     <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_inst_ok <= 1'b0;
            r_data_ok <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_inst_ok <= 1'b0;
            r_data_ok <= 1'b0;
            if (w_acc) begin
                r_req     <= w_acc_req;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_fire) r_aw_done <= 1'b1;
            if (w_w_fire)  r_w_done  <= 1'b1;
            if (r_state == ST_RD_DATA && rvalid) begin
                r_rdata   <= rdata;
                r_inst_ok <= (r_req.owner == OWN_INST);
                r_data_ok <= (r_req.owner == OWN_DATA);
            end
            if (r_state == ST_WR_RESP && bvalid) r_data_ok <= 1'b1;
        end
    end

    assign inst_data_ok = r_inst_ok;
    assign data_data_ok = r_data_ok;
    assign cpu_rdata    = r_rdata;

    assign arid   = (r_req.owner == OWN_DATA) ? DATA_ID : INST_ID;
    assign araddr = r_req.addr;
    assign arsize = {1'b0, r_req.size};
    assign awaddr = r_req.addr;
    assign awsize = {1'b0, r_req.size};
    assign wdata  = r_req.wdata;
    assign wstrb  = r_req.wstrb;

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
// Directed bench for cpu_axi_arbiter: a transaction-level reference model is
// checked every cycle on the falling edge, plus hand-computed spot checks.
module tb_cpu_axi_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] cpu_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    always #5 aclk = ~aclk;

    cpu_axi_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .cpu_rdata(cpu_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Strobe from first principles: 2^size bytes, naturally aligned, within a word.
    function automatic logic [3:0] exp_strb(input int sz, input int off);
        int nbytes;
        int base;
        if (sz >= 2) return 4'hF;
        nbytes = 1 << sz;
        base   = off - (off % nbytes);
        return 4'(((1 << nbytes) - 1) << base);
    endfunction

    // Reference model: one pending transaction and which of its handshakes are done.
    logic        m_busy = 1'b0, m_owner = 1'b0, m_wr = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [1:0]  m_size = '0;
    logic        m_ar_done = 1'b0, m_aw_done = 1'b0, m_w_done = 1'b0;
    logic        m_iok = 1'b0, m_dok = 1'b0;
    logic        e_iaok, e_daok, e_arv, e_rr, e_awv, e_wv, e_br;

    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_handshakes", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                                       arvalid, rready, awvalid, wvalid, bready}), 32'd0);
            chk("rst_cpu_rdata", cpu_rdata, 32'd0);
            m_busy = 0; m_rdata = '0; m_iok = 0; m_dok = 0;
        end else begin
            e_daok = !m_busy && data_req;
            e_iaok = !m_busy && inst_req && !data_req;
            e_arv  = m_busy && !m_wr && !m_ar_done;
            e_rr   = m_busy && !m_wr && m_ar_done;
            e_awv  = m_busy && m_wr && !m_aw_done;
            e_wv   = m_busy && m_wr && !m_w_done;
            e_br   = m_busy && m_wr && m_aw_done && m_w_done;
            chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
            chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
            chk("inst_data_ok", 32'(inst_data_ok), 32'(m_iok));
            chk("data_data_ok", 32'(data_data_ok), 32'(m_dok));
            chk("cpu_rdata", cpu_rdata, m_rdata);
            chk("arvalid", 32'(arvalid), 32'(e_arv));
            chk("rready", 32'(rready), 32'(e_rr));
            chk("awvalid", 32'(awvalid), 32'(e_awv));
            chk("wvalid", 32'(wvalid), 32'(e_wv));
            chk("bready", 32'(bready), 32'(e_br));
            if (e_arv) begin
                chk("arid", 32'(arid), m_owner ? 32'd1 : 32'd0);
                chk("araddr", araddr, m_addr);
                chk("arsize", 32'(arsize), 32'(m_size));
            end
            if (e_awv) begin
                chk("awaddr", awaddr, m_addr);
                chk("awsize", 32'(awsize), 32'(m_size));
            end
            if (e_wv) begin
                chk("wdata", wdata, m_wdata);
                chk("wstrb", 32'(wstrb), 32'(exp_strb(int'(m_size), int'(m_addr[1:0]))));
            end
            m_iok = 0;
            m_dok = 0;
            if (!m_busy) begin
                if (data_req) begin
                    m_busy = 1; m_owner = 1; m_wr = data_wr; m_addr = data_addr;
                    m_size = data_size; m_wdata = data_wdata;
                    m_ar_done = 0; m_aw_done = 0; m_w_done = 0;
                end else if (inst_req) begin
                    m_busy = 1; m_owner = 0; m_wr = 0; m_addr = inst_addr;
                    m_size = 2'd2; m_ar_done = 0;
                end
            end else if (!m_wr) begin
                if (e_arv) begin
                    if (arready) m_ar_done = 1;
                end else if (rvalid) begin
                    m_rdata = rdata; m_iok = !m_owner; m_dok = m_owner; m_busy = 0;
                end
            end else if (e_br) begin
                if (bvalid) begin m_dok = 1; m_busy = 0; end
            end else begin
                if (e_awv && awready) m_aw_done = 1;
                if (e_wv && wready)   m_w_done  = 1;
            end
        end
    end

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        aresetn = 0; inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0;
        data_size = '0; data_addr = '0; data_wdata = '0; arready = 0; rdata = '0;
        rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        tick; tick;
        chk("reset_arvalid", 32'(arvalid), 32'd0);
        aresetn = 1;

        // Inst read, zero-wait slave.
        tick; inst_req = 1; inst_addr = 32'hBFC0_0000; arready = 1; settle;
        chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        tick; inst_req = 0; settle;
        chk("t1_arvalid", 32'(arvalid), 32'd1);
        chk("t1_arid", 32'(arid), 32'd0);
        chk("t1_araddr", araddr, 32'hBFC0_0000);
        tick; rvalid = 1; rdata = 32'h3C08_0001; settle;
        chk("t1_rready", 32'(rready), 32'd1);
        tick; rvalid = 0; arready = 0; settle;
        chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t1_cpu_rdata", cpu_rdata, 32'h3C08_0001);
        tick; settle;
        chk("t1_ok_one_cycle", 32'(inst_data_ok), 32'd0);

        // Simultaneous requests: data wins, inst granted in the data_ok cycle.
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_1004; settle;
        chk("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("t2_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        tick; data_req = 0; arready = 1; settle;
        chk("t2_arid", 32'(arid), 32'd1);
        chk("t2_inst_blocked", 32'(inst_addr_ok), 32'd0);
        tick; arready = 0; rvalid = 1; rdata = 32'h1234_5678;
        tick; rvalid = 0; settle;
        chk("t2_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("t2_inst_granted", 32'(inst_addr_ok), 32'd1);
        chk("t2_cpu_rdata", cpu_rdata, 32'h1234_5678);
        tick; inst_req = 0; arready = 1; settle;
        chk("t2_inst_arid", 32'(arid), 32'd0);
        tick; arready = 0; rvalid = 1; rdata = 32'h0BAD_F00D;
        tick; rvalid = 0; settle;
        chk("t2_inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t2_inst_rdata", cpu_rdata, 32'h0BAD_F00D);

        // Byte write, W done first, AW delayed three cycles.
        tick; data_req = 1; data_wr = 1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'hAAAA_AAAA;
        tick; data_req = 0; wready = 1; settle;
        chk("t3_wstrb", 32'(wstrb), 32'h8);
        chk("t3_wvalid", 32'(wvalid), 32'd1);
        tick; wready = 0; settle;
        chk("t3_wvalid_dropped", 32'(wvalid), 32'd0);
        chk("t3_awvalid_held", 32'(awvalid), 32'd1);
        tick; settle;
        chk("t3_awvalid_held2", 32'(awvalid), 32'd1);
        tick; awready = 1; settle;
        chk("t3_awaddr", awaddr, 32'h8000_0003);
        tick; awready = 0; settle;
        chk("t3_bready", 32'(bready), 32'd1);
        bvalid = 1;
        tick; bvalid = 0; settle;
        chk("t3_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("t3_rdata_kept", cpu_rdata, 32'h0BAD_F00D);

        // Half write at addr[1]=1, AW and W together.
        tick; data_req = 1; data_wr = 1; data_size = 2'd1;
        data_addr = 32'h8000_0002; data_wdata = 32'hBEEF_BEEF;
        tick; data_req = 0; awready = 1; wready = 1; settle;
        chk("t4_wstrb", 32'(wstrb), 32'hC);
        tick; awready = 0; wready = 0; settle;
        chk("t4_bready", 32'(bready), 32'd1);
        chk("t4_aw_w_low", 32'({awvalid, wvalid}), 32'd0);
        bvalid = 1;
        tick; bvalid = 0; settle;
        chk("t4_data_data_ok", 32'(data_data_ok), 32'd1);

        // Strobe sweep over every size and byte offset.
        for (int sz = 0; sz < 4; sz++) begin
            for (int off = 0; off < 4; off++) begin
                tick; data_req = 1; data_wr = 1; data_size = 2'(sz);
                data_addr = 32'h8000_0100 + 32'(off); data_wdata = $urandom;
                tick; data_req = 0; awready = 1; wready = 1;
                tick; awready = 0; wready = 0; bvalid = 1;
                tick; bvalid = 0; settle;
                chk("sweep_ok", 32'(data_data_ok), 32'd1);
            end
        end

        // Reset while waiting in RD_DATA.
        tick; inst_req = 1; inst_addr = 32'h0000_1000; arready = 1;
        tick; inst_req = 0;
        tick; arready = 0; settle;
        chk("t5_rready_before", 32'(rready), 32'd1);
        aresetn = 0; settle;
        chk("t5_rready_rst", 32'(rready), 32'd0);
        chk("t5_rdata_rst", cpu_rdata, 32'd0);
        tick; tick; aresetn = 1;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_2000; settle;
        chk("t5_accept", 32'(data_addr_ok), 32'd1);
        tick; data_req = 0; arready = 1; settle;
        chk("t5_arid", 32'(arid), 32'd1);
        tick; arready = 0; rvalid = 1; rdata = 32'hCAFE_BABE;
        tick; rvalid = 0; settle;
        chk("t5_data_data_ok", 32'(data_data_ok), 32'd1);
        chk("t5_cpu_rdata", cpu_rdata, 32'hCAFE_BABE);

        tick; tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
